// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS div/divu: one quotient bit per cycle,
// fixed 32-cycle latency from the accepting edge to the done pulse.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one restoring step per cycle, 32 steps
  // DONE  | results valid, done pulse; start here chains the next operation
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] raw;
  logic             q_neg;
  logic             r_neg;
  logic             zero;

  logic             a_neg, b_neg, accept, last, ge;
  logic [WIDTH-1:0] a_mag, b_mag, quo_nx, q_res, r_res;
  logic [WIDTH:0]   rem_sh, rem_nx;

  always_comb begin
    a_neg  = is_signed & dividend[WIDTH-1];
    b_neg  = is_signed & divisor[WIDTH-1];
    a_mag  = a_neg ? (WIDTH'(0) - dividend) : dividend;
    b_mag  = b_neg ? (WIDTH'(0) - divisor) : divisor;
    accept = start && (state != RUN);
    last   = (cnt == CW'(WIDTH - 1));
    // quo doubles as the dividend shift register: its MSB feeds the remainder
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs});
    rem_nx = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
    quo_nx = {quo[WIDTH-2:0], ge};
    q_res  = q_neg ? (WIDTH'(0) - quo_nx) : quo_nx;
    r_res  = r_neg ? (WIDTH'(0) - rem_nx[WIDTH-1:0]) : rem_nx[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      raw         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      cnt   <= '0;
      rem   <= '0;
      quo   <= a_mag;
      dvs   <= b_mag;
      raw   <= dividend;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      zero  <= (divisor == '0);
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: done <= 1'b0;
        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (zero) begin
              quotient    <= '1;
              remainder   <= raw;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= q_res;
              remainder   <= r_res;
              div_by_zero <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for arithmetic results plus
// hand-written sequences for start-while-busy, back-to-back and mid-run reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives start across one rising edge (E0); returns 1 ns after E0 with cyc = 0.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
  endtask

  // Steps until done, checking busy on every cycle; returns the cycle index of done.
  task automatic wait_done(input string name, output int at);
    logic busy_ok;
    busy_ok = 1'b1;
    at = -1;
    for (int i = 0; i < 45; i++) begin
      step();
      if (done === 1'b1) begin
        at = cyc;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({name, " latency"}, 32'(at), 32'd32);
    chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    int at;
    int ndone;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[5] = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[7] = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
    vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0};
    vecs[9] = '{1'b0, 32'h80000000,   32'd2,          32'h40000000,   32'd0,          1'b0};

    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      launch(vecs[v].sgn, vecs[v].a, vecs[v].b);
      wait_done($sformatf("vec%0d", v), at);
      chk($sformatf("vec%0d quotient", v), quotient, vecs[v].q);
      chk($sformatf("vec%0d remainder", v), remainder, vecs[v].r);
      chk($sformatf("vec%0d dz", v), {31'd0, div_by_zero}, {31'd0, vecs[v].dz});
      repeat (5) step();
      chk($sformatf("vec%0d hold q", v), quotient, vecs[v].q);
      chk($sformatf("vec%0d hold r", v), remainder, vecs[v].r);
      chk($sformatf("vec%0d hold done", v), {31'd0, done}, 32'd0);
    end

    // start pulsed at E10 while busy must be ignored
    launch(1'b0, 32'd50, 32'd5);
    repeat (9) step();
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    step();
    start = 1'b0;
    wait_done("busy_start", at);
    chk("busy_start quotient", quotient, 32'd10);
    chk("busy_start remainder", remainder, 32'd0);
    ndone = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) ndone++;
    end
    chk("busy_start extra done", 32'(ndone), 32'd0);

    // back-to-back: start asserted during the DONE cycle
    launch(1'b0, 32'd50, 32'd5);
    wait_done("b2b first", at);
    chk("b2b first quotient", quotient, 32'd10);
    start = 1'b1; dividend = 32'd81; divisor = 32'd9;
    step();
    start = 1'b0;
    chk("b2b busy rerise", {31'd0, busy}, 32'd1);
    cyc = 0;
    wait_done("b2b second", at);
    chk("b2b second quotient", quotient, 32'd9);
    chk("b2b second remainder", remainder, 32'd0);

    // asynchronous reset in the middle of a run
    launch(1'b0, 32'd100, 32'd7);
    repeat (15) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst quotient", quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) ndone++;
    end
    chk("rst no done", 32'(ndone), 32'd0);
    launch(1'b0, 32'd9, 32'd4);
    wait_done("post_rst", at);
    chk("post_rst quotient", quotient, 32'd2);
    chk("post_rst remainder", remainder, 32'd1);
    chk("post_rst dz", {31'd0, div_by_zero}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit divider for the pipelined datapath, implementing MIPS `div`/`divu` by repeated shift-and-subtract (restoring division). Operands are accepted on a start pulse from the EX stage. The quotient and remainder are delivered to the HI/LO path a fixed number of cycles later. While the divider runs, the hazard unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width; the only supported value is 32.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only when `busy`=0.
- `is_signed`  in  1  1 = `div`, 0 = `divu`; captured with `start`.
- `dividend`  in  32  rs operand; captured with `start`.
- `divisor`  in  32  rt operand; captured with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `quotient`/`remainder` are valid.
- `quotient`  out  32  to LO.
- `remainder`  out  32  to HI.
- `div_by_zero`  out  1  divisor was 0 for the last operation; valid with `done`, held afterwards.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE.** `start`=1 moves to RUN and captures the following:
  - the operand magnitudes (two's-complement absolute value when `is_signed`, raw otherwise);
  - the sign flags `q_neg` = sign(dividend) XOR sign(divisor) and `r_neg` = sign(dividend), both forced to 0 when unsigned;
  - the zero flag.
  - The iteration counter is cleared to 0.
- **RUN.** Each cycle performs one restoring step on a 33-bit partial remainder:
  - shift {rem, quo} left by 1, bringing in the dividend MSB;
  - if rem ≥ divisor magnitude, subtract it and set the quotient LSB to 1, else set it to 0;
  - counter increments; after the 32nd step (counter = 31) go to DONE.
- **RUN → DONE result load.** The transition loads the result registers:
  - `quotient` = q_neg ? −quo : quo;
  - `remainder` = r_neg ? −rem : rem.
- **Divide by zero** overrides the result load: `quotient` = 32'hFFFFFFFF, `remainder` = captured raw dividend, `div_by_zero` = 1. Latency is unchanged.
- **Signed overflow.** 0x80000000 / 0xFFFFFFFF yields `quotient` = 0x80000000 and `remainder` = 0. This is the natural result of magnitude 2^31 with q_neg = 0; no special logic is used.
- **DONE.** Lasts exactly one cycle with `done`=1.
  - `start` in DONE is accepted: it goes directly to RUN with new operands.
  - Otherwise DONE returns to IDLE.
- Results and `div_by_zero` hold their value until the next RUN → DONE load.
- `start` while `busy`=1 is ignored: no capture and no effect on the running operation.
- Remainder sign follows the dividend, and |remainder| < |divisor| (MIPS semantics).

## Timing
- **Reset.** Asynchronous assertion of `rst_n`=0 forces IDLE and clears all of the following to 0: `busy`, `done`, `quotient`, `remainder`, `div_by_zero`, counter and internal registers.
  - Reset mid-RUN aborts the operation; no `done` is produced.
  - After release, the next `start` behaves as from power-up.
- `busy` rises in the cycle after the accepting edge (E0) and stays high for 32 cycles, E1 through E32.
- At edge E32 the state enters DONE and results register; `done`=1 from E32 to E33 and `busy`=0 in that cycle.
- Latency is 32 cycles from the accepting edge to `done`, independent of operand values, sign and divide-by-zero.
- Back-to-back throughput is one operation per 33 cycles when `start` is asserted in the DONE cycle.
- `start` must be a clean synchronous level; the block adds no edge detection.

## Test plan
- **Unsigned.** `divu`, 100 / 7, start at E0 → `busy` high E1–E32; `done` at E32 with `quotient`=14, `remainder`=2, `div_by_zero`=0; outputs still 14/2 five cycles later.
- **Signed sign rules.** `div` −7/2 → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1); 7/−2 → q=−3, r=1; −7/−2 → q=3, r=−1; signed overflow 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
- **Divide by zero and unsigned large operands.**
  - `divu` 0x12345678/0 → `done` at E32, q=0xFFFFFFFF, r=0x12345678, `div_by_zero`=1.
  - A following `divu` 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0, `div_by_zero`=0.
- **Start while busy.** 50/5 started; `start` pulsed with 9/3 at E10 → ignored; `done` at E32 with q=10, r=0; no second `done`.
- **Back-to-back.** 50/5 started; `start` with 81/9 asserted during the DONE cycle → `busy` re-rises next cycle; second `done` 32 cycles after that accepting edge with q=9, r=0.
- **Reset mid-operation.** `rst_n`=0 asynchronously at E15 (not on an edge) → `busy`, `done`, `quotient`, `remainder` read 0 immediately; no `done` after release; a new 9/4 returns q=2, r=1 with standard 32-cycle latency.
